// File: rtl/iomem_timer.sv
// iomem bus responder hosting a prescaled 32-bit down-counter with auto-reload
// and a level interrupt. Only requests inside its own 256-byte window are acknowledged.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_LOAD  = 8'h04;
  localparam logic [7:0] OFF_COUNT = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h0C;
  localparam logic [7:0] OFF_PRESC = 8'h10;

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        expired_q, expired_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] presc_cnt_q, presc_cnt_d;

  logic        sel;
  logic        bus_write;
  logic        wr_ctrl, wr_load, wr_count, wr_stat, wr_presc;
  logic [2:0]  ctrl_sw;
  logic        tick;
  logic        tick_eff;
  logic [31:0] rdata_mux;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = wd[i*8 +: 8];
    end
    return res;
  endfunction

  assign sel = (iomem_addr[31:8] == BASE_ADDR[31:8]);

  // IDLE -> WAIT (skipped when WAIT_STATES is 0) -> ACK -> IDLE; ACK always returns to IDLE,
  // so a requester still holding valid after its acknowledge never sees two consecutive readies.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iomem_valid && sel) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_ACK;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign iomem_ready = (state_q == ST_ACK);
  assign bus_write   = (state_q == ST_ACK) && iomem_valid && (iomem_wstrb != 4'b0000);

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_load  = 1'b0;
    wr_count = 1'b0;
    wr_stat  = 1'b0;
    wr_presc = 1'b0;
    if (bus_write) begin
      case (iomem_addr[7:0])
        OFF_CTRL:  wr_ctrl  = 1'b1;
        OFF_LOAD:  wr_load  = 1'b1;
        OFF_COUNT: wr_count = 1'b1;
        OFF_STAT:  wr_stat  = 1'b1;
        OFF_PRESC: wr_presc = 1'b1;
        default:   ;
      endcase
    end
  end

  // Software writes are applied first; the timer tick then sees the post-write CTRL,
  // so clearing en in the same cycle as a tick suppresses that tick entirely.
  always_comb begin
    ctrl_sw     = (wr_ctrl && iomem_wstrb[0]) ? iomem_wdata[2:0] : ctrl_q;
    load_d      = wr_load ? merge_bytes(load_q, iomem_wdata, iomem_wstrb) : load_q;
    presc_d     = presc_q;
    if (wr_presc) begin
      if (iomem_wstrb[0]) presc_d[7:0]  = iomem_wdata[7:0];
      if (iomem_wstrb[1]) presc_d[15:8] = iomem_wdata[15:8];
    end

    tick        = ctrl_q[0] && (presc_cnt_q >= presc_q);
    tick_eff    = tick && ctrl_sw[0];

    ctrl_d      = ctrl_sw;
    count_d     = count_q;
    expired_d   = expired_q;
    presc_cnt_d = presc_cnt_q;

    if (ctrl_q[0]) presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    if (!ctrl_sw[0]) presc_cnt_d = 16'd0;

    if (wr_stat && iomem_wstrb[0] && iomem_wdata[0]) expired_d = 1'b0;

    // Expiry is applied after the W1C so a simultaneous set wins.
    if (tick_eff) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (ctrl_sw[1]) count_d   = load_q;
        else            ctrl_d[0] = 1'b0;
      end
    end

    if (wr_count) count_d = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
  end

  always_comb begin
    rdata_mux = 32'h0;
    case (iomem_addr[7:0])
      OFF_CTRL:  rdata_mux = {29'h0, ctrl_q};
      OFF_LOAD:  rdata_mux = load_q;
      OFF_COUNT: rdata_mux = count_q;
      OFF_STAT:  rdata_mux = {31'h0, expired_q};
      OFF_PRESC: rdata_mux = {16'h0, presc_q};
      default:   rdata_mux = 32'h0;
    endcase
  end

  assign iomem_rdata = (state_q == ST_ACK) ? rdata_mux : 32'h0;
  assign irq         = expired_q && ctrl_q[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      ctrl_q      <= 3'd0;
      load_q      <= 32'd0;
      count_q     <= 32'd0;
      expired_q   <= 1'b0;
      presc_q     <= 16'd0;
      presc_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      count_q     <= count_d;
      expired_q   <= expired_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule
